// File: rtl/linebuffer_feeder.sv
// Sequencer feeding a 3-row line buffer: walks the image in 3-row bands, one column per
// FETCH/WRITE/SHIFT triple, and flags the cycles in which the buffer taps hold a valid column.
module linebuffer_feeder #(
   parameter int BIT_DEPTH = 8,
   parameter int IMG_W     = 8,
   parameter int IMG_H     = 8,
   parameter int ADDR_W    = 16,
   parameter int BASE_ADDR = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     mem_rd_en,
   output logic [ADDR_W-1:0]        mem_addr_r1,
   output logic [ADDR_W-1:0]        mem_addr_r2,
   output logic [ADDR_W-1:0]        mem_addr_r3,
   input  logic [BIT_DEPTH-1:0]     mem_data_r1,
   input  logic [BIT_DEPTH-1:0]     mem_data_r2,
   input  logic [BIT_DEPTH-1:0]     mem_data_r3,
   output logic                     lb_wr_en,
   output logic                     lb_shift,
   output logic [BIT_DEPTH-1:0]     lb_data_r1,
   output logic [BIT_DEPTH-1:0]     lb_data_r2,
   output logic [BIT_DEPTH-1:0]     lb_data_r3,
   output logic                     tap_valid,
   output logic [$clog2(IMG_H)-1:0] tap_row,
   output logic [$clog2(IMG_W)-1:0] tap_col
);
   localparam int ROW_W = $clog2(IMG_H);
   localparam int COL_W = $clog2(IMG_W);
   localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] LAST_BAND = ROW_W'(IMG_H - 3);

   typedef enum logic [2:0] {IDLE, FETCH, WRITE, SHIFT, FLUSH, DONE} state_t;

   state_t           state, state_nxt;
   logic [ROW_W-1:0] r;
   logic [COL_W-1:0] c;
   logic             last_col, last_band;

   // Row-major pixel address, widened to ADDR_W before any arithmetic so r+2 cannot overflow.
   function automatic logic [ADDR_W-1:0] pix_addr(input logic [ROW_W-1:0] row,
                                                  input logic [1:0]       k,
                                                  input logic [COL_W-1:0] col);
      return ADDR_W'(BASE_ADDR) + (ADDR_W'(row) + ADDR_W'(k)) * ADDR_W'(IMG_W) + ADDR_W'(col);
   endfunction

   assign last_col   = (c == LAST_COL);
   assign last_band  = (r == LAST_BAND);
   assign lb_data_r1 = mem_data_r1;
   assign lb_data_r2 = mem_data_r2;
   assign lb_data_r3 = mem_data_r3;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      busy        = 1'b0;
      done        = 1'b0;
      mem_rd_en   = 1'b0;
      lb_wr_en    = 1'b0;
      lb_shift    = 1'b0;
      mem_addr_r1 = '0;
      mem_addr_r2 = '0;
      mem_addr_r3 = '0;
      case (state)
         IDLE: if (start) state_nxt = FETCH;
         FETCH: begin
            busy        = 1'b1;
            mem_rd_en   = 1'b1;
            mem_addr_r1 = pix_addr(r, 2'd0, c);
            mem_addr_r2 = pix_addr(r, 2'd1, c);
            mem_addr_r3 = pix_addr(r, 2'd2, c);
            state_nxt   = WRITE;
         end
         WRITE: begin
            busy      = 1'b1;
            lb_wr_en  = 1'b1;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            busy      = 1'b1;
            lb_shift  = 1'b1;
            state_nxt = last_col ? FLUSH : FETCH;
         end
         FLUSH: begin
            busy      = 1'b1;
            lb_shift  = 1'b1;
            state_nxt = last_band ? DONE : FETCH;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Band/column counters and the tap tracker; a SHIFT of column c moves column c-1 to the taps.
   always_ff @(posedge clk) begin
      if (rst) begin
         r         <= '0;
         c         <= '0;
         tap_valid <= 1'b0;
         tap_row   <= '0;
         tap_col   <= '0;
      end else begin
         tap_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  r <= '0;
                  c <= '0;
               end
            end
            SHIFT: begin
               if (c != '0) begin
                  tap_valid <= 1'b1;
                  tap_row   <= r;
                  tap_col   <= c - COL_W'(1);
               end
               if (!last_col) c <= c + COL_W'(1);
            end
            FLUSH: begin
               tap_valid <= 1'b1;
               tap_row   <= r;
               tap_col   <= LAST_COL;
               if (!last_band) begin
                  r <= r + ROW_W'(1);
                  c <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_linebuffer_feeder.sv
// Bench for linebuffer_feeder: three instances (4x4, 8x8 at base 100, 2x3) against a
// reference that predicts fetch order, written data, tap order and frame timing.
module tb_linebuffer_feeder;

   typedef struct packed {
      logic       busy, done, rd, wr, sh, tv;
      logic [15:0] a1, a2, a3;
      logic [7:0]  d1, d2, d3, row, col;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [7:0] mem [256];

   logic        start_a = 1'b0, busy_a, done_a, rd_a, wr_a, sh_a, tv_a;
   logic [15:0] a1_a, a2_a, a3_a;
   logic [7:0]  md1_a, md2_a, md3_a, ld1_a, ld2_a, ld3_a;
   logic [1:0]  tr_a, tc_a;

   logic        start_b = 1'b0, busy_b, done_b, rd_b, wr_b, sh_b, tv_b;
   logic [15:0] a1_b, a2_b, a3_b;
   logic [7:0]  md1_b, md2_b, md3_b, ld1_b, ld2_b, ld3_b;
   logic [2:0]  tr_b, tc_b;

   logic        start_c = 1'b0, busy_c, done_c, rd_c, wr_c, sh_c, tv_c;
   logic [15:0] a1_c, a2_c, a3_c;
   logic [7:0]  md1_c, md2_c, md3_c, ld1_c, ld2_c, ld3_c;
   logic [1:0]  tr_c;
   logic [0:0]  tc_c;

   linebuffer_feeder #(.BIT_DEPTH(8), .IMG_W(4), .IMG_H(4), .ADDR_W(16), .BASE_ADDR(0)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .mem_rd_en(rd_a),
      .mem_addr_r1(a1_a), .mem_addr_r2(a2_a), .mem_addr_r3(a3_a),
      .mem_data_r1(md1_a), .mem_data_r2(md2_a), .mem_data_r3(md3_a),
      .lb_wr_en(wr_a), .lb_shift(sh_a), .lb_data_r1(ld1_a), .lb_data_r2(ld2_a), .lb_data_r3(ld3_a),
      .tap_valid(tv_a), .tap_row(tr_a), .tap_col(tc_a));

   linebuffer_feeder #(.BIT_DEPTH(8), .IMG_W(8), .IMG_H(8), .ADDR_W(16), .BASE_ADDR(100)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .mem_rd_en(rd_b),
      .mem_addr_r1(a1_b), .mem_addr_r2(a2_b), .mem_addr_r3(a3_b),
      .mem_data_r1(md1_b), .mem_data_r2(md2_b), .mem_data_r3(md3_b),
      .lb_wr_en(wr_b), .lb_shift(sh_b), .lb_data_r1(ld1_b), .lb_data_r2(ld2_b), .lb_data_r3(ld3_b),
      .tap_valid(tv_b), .tap_row(tr_b), .tap_col(tc_b));

   linebuffer_feeder #(.BIT_DEPTH(8), .IMG_W(2), .IMG_H(3), .ADDR_W(16), .BASE_ADDR(0)) dut_c (
      .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c), .mem_rd_en(rd_c),
      .mem_addr_r1(a1_c), .mem_addr_r2(a2_c), .mem_addr_r3(a3_c),
      .mem_data_r1(md1_c), .mem_data_r2(md2_c), .mem_data_r3(md3_c),
      .lb_wr_en(wr_c), .lb_shift(sh_c), .lb_data_r1(ld1_c), .lb_data_r2(ld2_c), .lb_data_r3(ld3_c),
      .tap_valid(tv_c), .tap_row(tr_c), .tap_col(tc_c));

   // Image memory with one-cycle read latency, one read port set per instance.
   always @(posedge clk) begin
      if (rd_a) begin md1_a <= mem[a1_a[7:0]]; md2_a <= mem[a2_a[7:0]]; md3_a <= mem[a3_a[7:0]]; end
      if (rd_b) begin md1_b <= mem[a1_b[7:0]]; md2_b <= mem[a2_b[7:0]]; md3_b <= mem[a3_b[7:0]]; end
      if (rd_c) begin md1_c <= mem[a1_c[7:0]]; md2_c <= mem[a2_c[7:0]]; md3_c <= mem[a3_c[7:0]]; end
   end

   obs_t       obs [3];
   obs_t       o;
   logic [1:0] sel = 2'd0;
   assign obs[0] = {busy_a, done_a, rd_a, wr_a, sh_a, tv_a, a1_a, a2_a, a3_a,
                    ld1_a, ld2_a, ld3_a, 8'(tr_a), 8'(tc_a)};
   assign obs[1] = {busy_b, done_b, rd_b, wr_b, sh_b, tv_b, a1_b, a2_b, a3_b,
                    ld1_b, ld2_b, ld3_b, 8'(tr_b), 8'(tc_b)};
   assign obs[2] = {busy_c, done_c, rd_c, wr_c, sh_c, tv_c, a1_c, a2_c, a3_c,
                    ld1_c, ld2_c, ld3_c, 8'(tr_c), 8'(tc_c)};
   assign o = obs[sel];

   int vectors = 0, miscompares = 0;
   int cyc = 0;
   int cw, ch, cb;
   int fetch_i, wr_i, tap_i, shift_n, busy_n, done_n, ffetch_cyc, done_cyc;

   task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
      vectors++;
      assert (obs_v === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs_v, exp_v);
      end
   endtask

   // Reference: the n-th fetch of a frame is band n/W, column n%W.
   function automatic int exp_addr(input int idx, input int k);
      return cb + (idx / cw + k) * cw + (idx % cw);
   endfunction

   task automatic select(input logic [1:0] s);
      sel = s;
      case (s)
         2'd0:    begin cw = 4; ch = 4; cb = 0;   end
         2'd1:    begin cw = 8; ch = 8; cb = 100; end
         default: begin cw = 2; ch = 3; cb = 0;   end
      endcase
   endtask

   task automatic set_start(input logic [1:0] s, input logic v);
      case (s)
         2'd0:    start_a = v;
         2'd1:    start_b = v;
         default: start_c = v;
      endcase
   endtask

   task automatic clear_mon();
      fetch_i = 0; wr_i = 0; tap_i = 0; shift_n = 0;
      busy_n = 0; done_n = 0; ffetch_cyc = -1; done_cyc = -1;
   endtask

   task automatic tick();
      int a;
      logic [15:0] oa [3];
      logic [7:0]  od [3];
      @(posedge clk);
      #1;
      cyc++;
      oa = '{o.a1, o.a2, o.a3};
      od = '{o.d1, o.d2, o.d3};
      if (o.wr || o.sh) chk("wr_shift_exclusive", 32'(o.wr & o.sh), 32'd0);
      if (o.rd) begin
         if (fetch_i == 0) ffetch_cyc = cyc;
         for (int k = 0; k < 3; k++) chk($sformatf("fetch%0d_addr_r%0d", fetch_i, k + 1),
                                         32'(oa[k]), 32'(exp_addr(fetch_i, k)));
         fetch_i++;
      end
      if (o.wr) begin
         chk("write_after_fetch", 32'(wr_i < fetch_i), 32'd1);
         for (int k = 0; k < 3; k++) begin
            a = exp_addr(wr_i, k);
            chk($sformatf("write%0d_data_r%0d", wr_i, k + 1), 32'(od[k]), 32'(mem[a % 256]));
         end
         wr_i++;
      end
      if (o.sh) shift_n++;
      if (o.tv) begin
         chk($sformatf("tap%0d_row", tap_i), 32'(o.row), 32'(tap_i / cw));
         chk($sformatf("tap%0d_col", tap_i), 32'(o.col), 32'(tap_i % cw));
         chk("tap_column_written", 32'(wr_i > tap_i), 32'd1);
         tap_i++;
      end
      if (o.busy) busy_n++;
      if (o.done) begin done_n++; done_cyc = cyc; end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, 32'(o.busy), 0);
      chk({tag, "_done"}, 32'(o.done), 0);
      chk({tag, "_rd_en"}, 32'(o.rd), 0);
      chk({tag, "_wr_en"}, 32'(o.wr), 0);
      chk({tag, "_shift"}, 32'(o.sh), 0);
      chk({tag, "_tap_valid"}, 32'(o.tv), 0);
      chk({tag, "_addr"}, 32'({o.a1, o.a2, o.a3} != 48'd0), 0);
      chk({tag, "_tap_row"}, 32'(o.row), 0);
      chk({tag, "_tap_col"}, 32'(o.col), 0);
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 2000 && done_n == 0; i++) tick();
      chk({name, "_done_seen"}, 32'(done_n), 32'd1);
   endtask

   task automatic check_counts(input string name);
      int bands = ch - 2;
      chk({name, "_fetches"}, 32'(fetch_i), 32'(cw * bands));
      chk({name, "_writes"}, 32'(wr_i), 32'(cw * bands));
      chk({name, "_shifts"}, 32'(shift_n), 32'((cw + 1) * bands));
      chk({name, "_taps"}, 32'(tap_i), 32'(cw * bands));
      chk({name, "_busy_cycles"}, 32'(busy_n), 32'(bands * (3 * cw + 1) + 1));
      chk({name, "_done_offset"}, 32'(done_cyc - ffetch_cyc), 32'(bands * (3 * cw + 1)));
   endtask

   task automatic frame(input logic [1:0] s, input string name);
      int st, n;
      select(s);
      repeat ($urandom_range(0, 4)) tick();
      clear_mon();
      set_start(s, 1'b1);
      st = cyc;
      n = $urandom_range(1, 3);
      repeat (n) tick();
      set_start(s, 1'b0);
      wait_done(name);
      chk({name, "_start_latency"}, 32'(ffetch_cyc - st), 32'd1);
      check_counts(name);
      tick();
      chk({name, "_idle_after_done"}, 32'(o.busy), 32'd0);
   endtask

   initial begin
      bit found;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      clear_mon();
      select(2'd0);
      repeat (3) tick();
      rst = 1'b0;
      for (int s = 0; s < 3; s++) begin
         select(2'(s));
         chk_idle($sformatf("reset_inst%0d", s));
      end

      frame(2'd0, "frame_4x4");
      frame(2'd2, "frame_2x3");
      frame(2'd1, "frame_8x8");

      // Reset during the SHIFT of band 1, column 2, then a clean restart.
      select(2'd1);
      clear_mon();
      set_start(2'd1, 1'b1);
      tick();
      set_start(2'd1, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 1000 && !found; i++) begin
         tick();
         if (o.sh && shift_n == 12) found = 1'b1;
      end
      chk("reset_point_reached", 32'(found), 32'd1);
      rst = 1'b1;
      tick();
      chk_idle("mid_band_reset");
      rst = 1'b0;
      frame(2'd1, "after_reset");

      // start held through a whole frame: no restart while busy, then restart from IDLE.
      select(2'd1);
      clear_mon();
      set_start(2'd1, 1'b1);
      wait_done("held_start");
      check_counts("held_start");
      tick();
      chk("held_idle_after_done", 32'(o.busy), 32'd0);
      clear_mon();
      tick();
      chk("held_restart_fetch", 32'(o.rd), 32'd1);
      set_start(2'd1, 1'b0);
      wait_done("held_second");
      check_counts("held_second");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
